// File: rtl/sram_axi_bridge.sv
// Round-robin bridge from NUM_CH sram-like request channels to a single AXI4 master port.
// One transaction is in flight at a time, so ordering between channels is trivially preserved.
module sram_axi_bridge #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [2*NUM_CH-1:0]      ch_size,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_addr_ok,
  output logic [NUM_CH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ID_W-1:0]          arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [2:0]               arsize,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [DATA_W-1:0]        rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [ID_W-1:0]          awid,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [2:0]               awsize,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_W-1:0]        wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [ID_W-1:0]          bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1'b1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [PTR_W-1:0]    grant_r;
  logic [PTR_W-1:0]    grant_s;
  logic                grant_vld_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          size_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [3:0]          wstrb_r;
  logic                aw_done_r;
  logic                w_done_r;
  logic                aw_done_s;
  logic                w_done_s;
  logic [NUM_CH-1:0]   req_shift_s;
  int                  idx_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [1:0]          sel_size_s;
  logic                unused_s;

  // Byte-lane strobe for a narrow write; size 3 falls back to a full word.
  function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Round-robin search: first requester at or after rr_ptr_r, wrapping.
  always_comb begin
    grant_s     = {PTR_W{1'b0}};
    grant_vld_s = 1'b0;
    idx_s       = 0;
    req_shift_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      idx_s       = (int'(rr_ptr_r) + i) % NUM_CH;
      req_shift_s = ch_req >> idx_s;
      grant_s     = (req_shift_s[0] && !grant_vld_s) ? PTR_W'(idx_s) : grant_s;
      grant_vld_s = grant_vld_s | req_shift_s[0];
    end
  end

  assign sel_addr_s = ch_addr[int'(grant_s)*ADDR_W +: ADDR_W];
  assign sel_size_s = ch_size[int'(grant_s)*2 +: 2];

  assign aw_done_s = aw_done_r | (awvalid & awready);
  assign w_done_s  = w_done_r  | (wvalid  & wready);

  // Next-state logic for the single-outstanding transaction sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_vld_s) begin
          state_s = ch_wr[grant_s] ? WR_REQ : RD_ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          state_s = RD_DATA;
        end else begin
          state_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          state_s = IDLE;
        end else begin
          state_s = RD_DATA;
        end
      end
      WR_REQ: begin
        if (aw_done_s && w_done_s) begin
          state_s = WR_RESP;
        end else begin
          state_s = WR_REQ;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_s = IDLE;
        end else begin
          state_s = WR_RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, pointer and per-transaction request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      rr_ptr_r  <= {PTR_W{1'b0}};
      grant_r   <= {PTR_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      size_r    <= 2'd0;
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= 4'd0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && grant_vld_s) begin
        grant_r  <= grant_s;
        addr_r   <= sel_addr_s;
        size_r   <= sel_size_s;
        wdata_r  <= ch_wdata[int'(grant_s)*DATA_W +: DATA_W];
        wstrb_r  <= calc_wstrb(sel_size_s, sel_addr_s[1:0]);
        rr_ptr_r <= (int'(grant_s) == NUM_CH - 1) ? {PTR_W{1'b0}} : grant_s + PTR_W'(1'b1);
      end
      // Done flags only live inside WR_REQ; they start clear on every new write.
      aw_done_r <= (state_r == WR_REQ) ? aw_done_s : 1'b0;
      w_done_r  <= (state_r == WR_REQ) ? w_done_s  : 1'b0;
    end
  end

  assign ch_addr_ok = (state_r == IDLE && grant_vld_s) ? (CH_ONE << grant_s) : {NUM_CH{1'b0}};
  assign ch_data_ok = ((state_r == RD_DATA && rvalid) || (state_r == WR_RESP && bvalid))
                      ? (CH_ONE << grant_r) : {NUM_CH{1'b0}};
  assign ch_rdata   = rdata;

  assign arid    = ID_W'(grant_r);
  assign araddr  = addr_r;
  assign arsize  = {1'b0, size_r};
  assign arvalid = (state_r == RD_ADDR);
  assign rready  = (state_r == RD_DATA);

  assign awid    = ID_W'(grant_r);
  assign awaddr  = addr_r;
  assign awsize  = {1'b0, size_r};
  assign awvalid = (state_r == WR_REQ) && !aw_done_r;
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = 1'b1;
  assign wvalid  = (state_r == WR_REQ) && !w_done_r;
  assign bready  = (state_r == WR_RESP);

  // Response IDs and status are not acted on by this bridge.
  assign unused_s = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: directed requests push expectations, a negedge
// monitor pops and compares them against AXI handshakes and ok pulses.
module tb_sram_axi_bridge;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_wr;
  logic [2*NUM_CH-1:0]      ch_size;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;
  logic [DATA_W*NUM_CH-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_addr_ok, ch_data_ok;
  logic [DATA_W-1:0]        ch_rdata;
  logic [ID_W-1:0]          arid, rid, awid, bid;
  logic [ADDR_W-1:0]        araddr, awaddr;
  logic [2:0]               arsize, awsize;
  logic                     arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0]        rdata, wdata;
  logic [1:0]               rresp, bresp;
  logic                     awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]               wstrb;

  sram_axi_bridge #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
    .ch_rdata(ch_rdata), .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } a_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct { int ch; bit wr; logic [31:0] rdata; int lat; } r_t;

  a_t exp_ar[$];
  a_t exp_aw[$];
  w_t exp_w[$];
  r_t exp_resp[$];
  int exp_grant[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int grant_cyc [NUM_CH];

  int ar_stall = 0, aw_stall = 0, w_stall = 0, r_stall = 0, b_stall = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  logic [31:0] r_value = 32'h0;
  logic [3:0]  last_arid = 4'h0, last_awid = 4'h0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=present required=none", name);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Zero-wait-capable AXI slave with per-channel stall knobs.
  always @(posedge clk or posedge reset) begin
    #1;
    if (reset) begin
      arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      rdata = 32'h0;
    end else begin
      if (arvalid) begin arready = (ar_cnt >= ar_stall); ar_cnt++; end
      else begin arready = 1'b0; ar_cnt = 0; end
      if (awvalid) begin awready = (aw_cnt >= aw_stall); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_stall); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (rready) begin rvalid = (r_cnt >= r_stall); r_cnt++; end
      else begin rvalid = 1'b0; r_cnt = 0; end
      if (bready) begin bvalid = (b_cnt >= b_stall); b_cnt++; end
      else begin bvalid = 1'b0; b_cnt = 0; end
      rdata = rvalid ? r_value : 32'h0;
    end
    rid = last_arid;
    bid = last_awid;
  end

  // Monitor: compare every output event against the head of its expectation queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (ch_addr_ok != '0) begin
        if (exp_grant.size() == 0) unexpected("grant");
        else begin
          int g;
          g = exp_grant.pop_front();
          chk("addr_ok", 64'(ch_addr_ok), 64'(2'b01 << g));
          grant_cyc[g] = cyc;
        end
      end
      if (arvalid) begin
        if (exp_ar.size() == 0) unexpected("arvalid");
        else begin
          chk("arid", 64'(arid), 64'(exp_ar[0].id));
          chk("araddr", 64'(araddr), 64'(exp_ar[0].addr));
          chk("arsize", 64'(arsize), 64'(exp_ar[0].size));
          if (arready) begin last_arid = arid; void'(exp_ar.pop_front()); end
        end
      end
      if (awvalid) begin
        if (exp_aw.size() == 0) unexpected("awvalid");
        else begin
          chk("awid", 64'(awid), 64'(exp_aw[0].id));
          chk("awaddr", 64'(awaddr), 64'(exp_aw[0].addr));
          chk("awsize", 64'(awsize), 64'(exp_aw[0].size));
          if (awready) begin last_awid = awid; void'(exp_aw.pop_front()); end
        end
      end
      if (wvalid) begin
        if (exp_w.size() == 0) unexpected("wvalid");
        else begin
          chk("wdata", 64'(wdata), 64'(exp_w[0].data));
          chk("wstrb", 64'(wstrb), 64'(exp_w[0].strb));
          chk("wlast", 64'(wlast), 64'(1'b1));
          if (wready) void'(exp_w.pop_front());
        end
      end
      if (ch_data_ok != '0) begin
        if (exp_resp.size() == 0) unexpected("data_ok");
        else begin
          r_t e;
          e = exp_resp.pop_front();
          chk("data_ok", 64'(ch_data_ok), 64'(2'b01 << e.ch));
          if (e.wr) chk("data_ok_with_b", 64'(bvalid && bready), 64'(1'b1));
          else begin
            chk("data_ok_with_r", 64'(rvalid && rready), 64'(1'b1));
            chk("ch_rdata", 64'(ch_rdata), 64'(e.rdata));
          end
          if (e.lat >= 0) chk("latency", 64'(cyc - grant_cyc[e.ch]), 64'(e.lat));
        end
      end
    end
  end

  task automatic exp_read(input int ch, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] data, input int lat);
    a_t a; r_t r;
    a.id = 4'(ch); a.addr = addr; a.size = size;
    r.ch = ch; r.wr = 1'b0; r.rdata = data; r.lat = lat;
    exp_grant.push_back(ch); exp_ar.push_back(a); exp_resp.push_back(r);
  endtask

  task automatic exp_write(input int ch, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] data, input logic [3:0] strb, input int lat);
    a_t a; w_t w; r_t r;
    a.id = 4'(ch); a.addr = addr; a.size = size;
    w.data = data; w.strb = strb;
    r.ch = ch; r.wr = 1'b1; r.rdata = 32'h0; r.lat = lat;
    exp_grant.push_back(ch); exp_aw.push_back(a); exp_w.push_back(w); exp_resp.push_back(r);
  endtask

  task automatic set_ch(input int ch, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] data);
    ch_wr[ch] = wr;
    ch_size[2*ch +: 2] = size;
    ch_addr[ADDR_W*ch +: ADDR_W] = addr;
    ch_wdata[DATA_W*ch +: DATA_W] = data;
  endtask

  task automatic issue(input int ch, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
    bit seen;
    @(posedge clk); #1;
    set_ch(ch, wr, size, addr, data);
    ch_req[ch] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = ch_addr_ok[ch];
    end
    if (!seen) begin failures++; checks++; $display("FAIL addr_ok_timeout actual=none required=ch%0d", ch); end
    @(posedge clk); #1;
    ch_req[ch] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      done = (exp_grant.size() == 0) && (exp_ar.size() == 0) && (exp_aw.size() == 0)
             && (exp_w.size() == 0) && (exp_resp.size() == 0);
    end
    if (!done) begin
      failures++; checks++;
      $display("FAIL %s_drain actual=pending required=empty", name);
    end
  endtask

  initial begin
    reset = 1'b1;
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
    rresp = 2'b00; bresp = 2'b00; rlast = 1'b1;
    arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    rdata = 32'h0; rid = 4'h0; bid = 4'h0;
    for (int i = 0; i < NUM_CH; i++) grant_cyc[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", 64'(arvalid), 64'(1'b0));
    chk("rst_awvalid", 64'(awvalid), 64'(1'b0));
    chk("rst_wvalid", 64'(wvalid), 64'(1'b0));
    chk("rst_rready", 64'(rready), 64'(1'b0));
    chk("rst_bready", 64'(bready), 64'(1'b0));
    chk("rst_oks", 64'({ch_addr_ok, ch_data_ok}), 64'(4'b0000));
    chk("rst_araddr", 64'(araddr), 64'(32'h0));
    chk("rst_wdata_wstrb", 64'({wdata, wstrb}), 64'(36'h0));
    @(posedge clk); #1 reset = 1'b0;

    // Single word read on ch0.
    r_value = 32'h3C08BFAF;
    exp_read(0, 32'hBFC00000, 3'd2, 32'h3C08BFAF, 2);
    issue(0, 1'b0, 2'd2, 32'hBFC00000, 32'h0);
    wait_drain("read");

    // Byte write on ch1 with a slow B response.
    b_stall = 2;
    exp_write(1, 32'h80001002, 3'd0, 32'h00AB0000, 4'b0100, 4);
    issue(1, 1'b1, 2'd0, 32'h80001002, 32'h00AB0000);
    wait_drain("byte_write");
    b_stall = 0;

    // Half-word write with W held off for 3 cycles after AW completes.
    w_stall = 3;
    exp_write(0, 32'h00000012, 3'd1, 32'hBEEF0000, 4'b1100, 5);
    issue(0, 1'b1, 2'd1, 32'h00000012, 32'hBEEF0000);
    wait_drain("w_skew");
    w_stall = 0;

    // Read with AR backpressure of 5 cycles.
    ar_stall = 5;
    r_value = 32'h12345678;
    exp_read(1, 32'h00000100, 3'd2, 32'h12345678, 7);
    issue(1, 1'b0, 2'd2, 32'h00000100, 32'h0);
    wait_drain("ar_backpressure");
    ar_stall = 0;

    // Both channels requesting continuously: strict alternation.
    r_value = 32'h55AA00FF;
    exp_read(0, 32'h10000001, 3'd0, 32'h55AA00FF, -1);
    exp_write(1, 32'h20000004, 3'd3, 32'hCAFEF00D, 4'b1111, -1);
    exp_read(0, 32'h10000001, 3'd0, 32'h55AA00FF, -1);
    exp_write(1, 32'h20000004, 3'd3, 32'hCAFEF00D, 4'b1111, -1);
    @(posedge clk); #1;
    set_ch(0, 1'b0, 2'd0, 32'h10000001, 32'h0);
    set_ch(1, 1'b1, 2'd3, 32'h20000004, 32'hCAFEF00D);
    ch_req = 2'b11;
    for (int i = 0; i < 100 && exp_grant.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1 ch_req = 2'b00;
    wait_drain("arbitration");

    // Reset while waiting for read data, then the pointer must restart at ch0.
    r_stall = 10;
    exp_grant.push_back(0);
    begin
      a_t a;
      a.id = 4'd0; a.addr = 32'h00000040; a.size = 3'd2;
      exp_ar.push_back(a);
    end
    issue(0, 1'b0, 2'd2, 32'h00000040, 32'h0);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    chk("rd_data_reached", 64'(rready), 64'(1'b1));
    #1 reset = 1'b1;
    #1;
    chk("rst_async_rready", 64'(rready), 64'(1'b0));
    chk("rst_async_arvalid", 64'(arvalid), 64'(1'b0));
    chk("rst_async_data_ok", 64'(ch_data_ok), 64'(2'b00));
    exp_grant.delete(); exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_resp.delete();
    r_stall = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    r_value = 32'h0BADF00D;
    exp_read(0, 32'h00000080, 3'd2, 32'h0BADF00D, -1);
    exp_read(1, 32'h00000084, 3'd2, 32'h0BADF00D, -1);
    @(posedge clk); #1;
    set_ch(0, 1'b0, 2'd2, 32'h00000080, 32'h0);
    set_ch(1, 1'b0, 2'd2, 32'h00000084, 32'h0);
    ch_req = 2'b11;
    for (int i = 0; i < 60 && exp_grant.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1 ch_req = 2'b00;
    wait_drain("post_reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
